udma_filter_thresh_cnt: RTL and testbench
=========================================

Name: udma_filter_thresh_cnt

Overview:
- Downstream stage of the uDMA filter arithmetic unit. Consumes the AU result stream (data, datasize, valid/ready).
- Compares each sample against a programmable threshold and emits a binarized stream (1 = above threshold) to the RX write channel.
- Counts above-threshold hits over a frame of programmable length.
- Raises a one-cycle event when the hit count reaches a programmed target, and a done pulse at end of frame.

Parameters:
DATA_WIDTH, 32, width of input and output sample data
TRANS_SIZE, 16, width of frame-length and counter registers

Ports:
clk_i  in  1  clock
resetn_i  in  1  asynchronous active-low reset
cfg_use_signed_i  in  1  1 = signed compare, 0 = unsigned compare
cfg_out_enable_i  in  1  1 = forward binarized stream; 0 = consume only
cfg_threshold_i  in  DATA_WIDTH  compare threshold
cfg_len_i  in  TRANS_SIZE  frame length in samples
cfg_count_i  in  TRANS_SIZE  hit count that fires act_event_o
cfg_datasize_i  in  2  datasize tagged onto output samples
cmd_start_i  in  1  start/restart frame
input_data_i  in  DATA_WIDTH  AU result
input_datasize_i  in  2  AU result size: 00 = 8b, 01 = 16b, other = 32b
input_valid_i  in  1  input valid
input_ready_o  out  1  input ready
output_data_o  out  DATA_WIDTH  binarized sample; bit0 = hit, rest 0
output_datasize_o  out  2  equals cfg_datasize_i
output_valid_o  out  1  output valid
output_ready_i  in  1  output ready
act_event_o  out  1  one-cycle pulse when hit count reaches cfg_count_i
done_o  out  1  one-cycle pulse at frame end
busy_o  out  1  high in RUN and DRAIN
count_o  out  TRANS_SIZE  hit count; held after frame until next start

Behaviour:
Reset state:
- FSM = IDLE.
- All outputs 0, except output_datasize_o, which follows cfg_datasize_i.
- Counters 0.

FSM states: IDLE, RUN, DRAIN.
- IDLE: input_ready_o = 0.
- cmd_start_i in any state: clear sample_cnt, hit_cnt, output register and event flag, then go to RUN.
  - Exception: if cfg_len_i == 0, go directly to DRAIN.
  - Start takes priority over any simultaneous input handshake; that sample is dropped.
- RUN:
  - input_ready_o = !cfg_out_enable_i | !output_valid_o | output_ready_i.
  - A transfer is input_valid_i & input_ready_o.
  - On each transfer, sample_cnt increments.
  - When sample_cnt + 1 == cfg_len_i on a transfer, go to DRAIN.
- DRAIN:
  - input_ready_o = 0.
  - Stay until output_valid_o == 0 (or immediately if !cfg_out_enable_i).
  - Then pulse done_o for one cycle and go to IDLE.

Compare rule:
- Extend the input per input_datasize_i:
  - 8b uses bits [7:0]; 16b uses bits [15:0].
  - Sign-extend if cfg_use_signed_i, else zero-extend.
- hit = extended value > cfg_threshold_i, signed or unsigned per cfg_use_signed_i. Equality is not a hit.

Output register:
- Single-entry, one-cycle latency: a sample accepted in cycle N is presented in cycle N+1 when cfg_out_enable_i = 1.
- output_valid_o holds until output_ready_i.
- Data and datasize are stable while valid and not ready.
- Back-to-back throughput is 1 sample/cycle when output_ready_i stays high.

Hit counter:
- hit_cnt saturates at all-ones.
- count_o = hit_cnt.

Event:
- act_event_o pulses the cycle after the transfer that makes hit_cnt == cfg_count_i.
- Fires at most once per frame.
- Never fires if cfg_count_i == 0.

Config:
- Config changes during RUN are not supported; the frame result is undefined.
- Reset mid-frame returns to IDLE immediately; no done_o pulse.

Test Plan:
- Unsigned, thr = 100, len = 4, inputs 50, 100, 101, 300 (32b), output_ready_i = 1 -> output bits 0, 0, 1, 1 each one cycle after accept; count_o = 2; done_o pulses once after last output.
- Signed, 8b, thr = 0, inputs 0xFF, 0x01, 0x80 -> hits 0, 1, 0. Same inputs unsigned -> 1, 1, 1.
- count = 2, len = 5, hits on samples 2 and 4 -> act_event_o single pulse the cycle after sample 4; no further pulse.
- output_ready_i held low 3 cycles with valid pending -> input_ready_o = 0, output data stable, no loss. Release -> stream resumes, all 4 samples delivered in order.
- cmd_start_i mid-frame after 2 of 4 samples -> counters clear, pending output dropped, new frame of 4 needed before done_o. Also cfg_len_i = 0 -> done_o pulses within 2 cycles of start with no input accepted.
- cfg_out_enable_i = 0, len = 3 -> output_valid_o never asserted, input accepted every cycle, count_o correct, done_o pulses.

Source files
------------

// File: rtl/udma_filter_thresh_cnt_if.sv
// Valid/ready sample stream carrying a data word and its 2-bit datasize tag.
// The producer uses the master modport and the consumer uses the slave modport.
//   data     : sample word
//   datasize : 00 = 8b, 01 = 16b, other = 32b
//   valid    : producer has a sample this cycle
//   ready    : consumer accepts the sample this cycle
interface udma_filter_thresh_cnt_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            datasize;
    logic                  valid;
    logic                  ready;

    modport master (output data, output datasize, output valid, input  ready);
    modport slave  (input  data, input  datasize, input  valid, output ready);
endinterface

// File: rtl/udma_filter_thresh_cnt.sv
// Threshold/count stage behind the uDMA filter arithmetic unit.
// Each AU sample is compared against a programmable threshold. The 1-bit
// result is forwarded as a binarized stream, and hits are counted over a
// frame of cfg_len_i samples.
// Ports:
//   clk_i, resetn_i    : clock, asynchronous active-low reset
//   cfg_*              : signedness, output enable, threshold, frame length,
//                        event hit count, output datasize tag
//   cmd_start_i        : start or restart a frame (highest priority)
//   in_s               : AU result stream (slave)
//   out_m              : binarized stream to the RX write channel (master)
//   act_event_o        : one-cycle pulse when the hit count reaches cfg_count_i
//   done_o             : one-cycle pulse at the end of the frame
//   busy_o             : frame in progress (RUN or DRAIN)
//   count_o            : hit count, held after the frame until the next start
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no frame active, input stalled
// ST_RUN   | accepting samples until cfg_len_i have been taken
// ST_DRAIN | all samples taken, waiting for the output register to empty
module udma_filter_thresh_cnt #(
    parameter int DATA_WIDTH = 32,
    parameter int TRANS_SIZE = 16
) (
    input  logic                     clk_i,
    input  logic                     resetn_i,
    input  logic                     cfg_use_signed_i,
    input  logic                     cfg_out_enable_i,
    input  logic [DATA_WIDTH-1:0]    cfg_threshold_i,
    input  logic [TRANS_SIZE-1:0]    cfg_len_i,
    input  logic [TRANS_SIZE-1:0]    cfg_count_i,
    input  logic [1:0]               cfg_datasize_i,
    input  logic                     cmd_start_i,
    udma_filter_thresh_cnt_if.slave  in_s,
    udma_filter_thresh_cnt_if.master out_m,
    output logic                     act_event_o,
    output logic                     done_o,
    output logic                     busy_o,
    output logic [TRANS_SIZE-1:0]    count_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t                state_q, state_d;
    logic [TRANS_SIZE-1:0] sample_cnt_q, hit_cnt_q;
    logic [TRANS_SIZE-1:0] sample_cnt_inc, hit_cnt_inc;
    logic                  out_valid_q, out_hit_q;
    logic                  event_fired_q, act_event_q;
    logic                  in_ready, xfer, hit, sign_bit;
    logic [DATA_WIDTH-1:0] sample_ext;

    assign sample_cnt_inc = sample_cnt_q + TRANS_SIZE'(1);
    assign hit_cnt_inc    = hit_cnt_q + TRANS_SIZE'(1);

    // Narrow samples are widened to the threshold width before the compare.
    // The sign bit is only replicated in signed mode.
    always_comb begin
        sign_bit   = 1'b0;
        sample_ext = in_s.data;
        case (in_s.datasize)
            2'b00: begin
                sign_bit   = cfg_use_signed_i & in_s.data[7];
                sample_ext = {{(DATA_WIDTH-8){sign_bit}}, in_s.data[7:0]};
            end
            2'b01: begin
                sign_bit   = cfg_use_signed_i & in_s.data[15];
                sample_ext = {{(DATA_WIDTH-16){sign_bit}}, in_s.data[15:0]};
            end
            default: sample_ext = in_s.data;
        endcase
    end

    assign hit = cfg_use_signed_i ? ($signed(sample_ext) > $signed(cfg_threshold_i))
                                  : (sample_ext > cfg_threshold_i);

    // A start in the same cycle wins over a handshake, so that sample is dropped.
    assign xfer = in_s.valid & in_ready & ~cmd_start_i;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        done_o   = 1'b0;
        busy_o   = 1'b0;
        case (state_q)
            ST_IDLE: ;
            ST_RUN: begin
                busy_o   = 1'b1;
                in_ready = ~cfg_out_enable_i | ~out_valid_q | out_m.ready;
                if (in_s.valid && in_ready && sample_cnt_inc == cfg_len_i)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy_o = 1'b1;
                if (!cfg_out_enable_i || !out_valid_q) begin
                    done_o  = ~cmd_start_i;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (cmd_start_i)
            state_d = (cfg_len_i == '0) ? ST_DRAIN : ST_RUN;
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            sample_cnt_q  <= '0;
            hit_cnt_q     <= '0;
            out_valid_q   <= 1'b0;
            out_hit_q     <= 1'b0;
            event_fired_q <= 1'b0;
            act_event_q   <= 1'b0;
        end else if (cmd_start_i) begin
            sample_cnt_q  <= '0;
            hit_cnt_q     <= '0;
            out_valid_q   <= 1'b0;
            out_hit_q     <= 1'b0;
            event_fired_q <= 1'b0;
            act_event_q   <= 1'b0;
        end else begin
            act_event_q <= 1'b0;
            if (out_valid_q && out_m.ready)
                out_valid_q <= 1'b0;
            if (xfer) begin
                sample_cnt_q <= sample_cnt_inc;
                if (cfg_out_enable_i) begin
                    out_valid_q <= 1'b1;
                    out_hit_q   <= hit;
                end
                // Once saturated the count can no longer move, so it cannot
                // newly reach the target either.
                if (hit && !(&hit_cnt_q)) begin
                    hit_cnt_q <= hit_cnt_inc;
                    if (!event_fired_q && cfg_count_i != '0 && hit_cnt_inc == cfg_count_i) begin
                        act_event_q   <= 1'b1;
                        event_fired_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign in_s.ready     = in_ready;
    assign out_m.valid    = out_valid_q;
    assign out_m.data     = {{(DATA_WIDTH-1){1'b0}}, out_hit_q};
    assign out_m.datasize = cfg_datasize_i;
    assign act_event_o    = act_event_q;
    assign count_o        = hit_cnt_q;

endmodule

// File: tb/tb_udma_filter_thresh_cnt.sv
module tb_udma_filter_thresh_cnt;

    localparam longint P8  = 64'd256;
    localparam longint P16 = 64'd65536;
    localparam longint P31 = 64'h8000_0000;
    localparam longint P32 = 64'h1_0000_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_use_signed = 1'b0;
    logic        cfg_out_enable = 1'b1;
    logic [31:0] cfg_threshold = '0;
    logic [15:0] cfg_len = '0;
    logic [15:0] cfg_count = '0;
    logic [1:0]  cfg_datasize = 2'b10;
    logic        cmd_start = 1'b0;
    logic        act_event, done, busy;
    logic [15:0] count;

    udma_filter_thresh_cnt_if #(.DATA_WIDTH(32)) in_if ();
    udma_filter_thresh_cnt_if #(.DATA_WIDTH(32)) out_if ();

    udma_filter_thresh_cnt #(.DATA_WIDTH(32), .TRANS_SIZE(16)) dut (
        .clk_i            (clk),
        .resetn_i         (resetn),
        .cfg_use_signed_i (cfg_use_signed),
        .cfg_out_enable_i (cfg_out_enable),
        .cfg_threshold_i  (cfg_threshold),
        .cfg_len_i        (cfg_len),
        .cfg_count_i      (cfg_count),
        .cfg_datasize_i   (cfg_datasize),
        .cmd_start_i      (cmd_start),
        .in_s             (in_if.slave),
        .out_m            (out_if.master),
        .act_event_o      (act_event),
        .done_o           (done),
        .busy_o           (busy),
        .count_o          (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] smp[16];
    logic [1:0]  ssz[16];
    bit          exp_hit[16];
    bit          rx_bits[16];
    int          rx_total;
    int          last_ev_seen;

    // Reference compare: interpret the sample and threshold as plain integers.
    function automatic bit model_hit(logic [31:0] d, logic [1:0] sz, bit sgn, logic [31:0] thr);
        longint v, t;
        case (sz)
            2'b00:   v = longint'(d[7:0]);
            2'b01:   v = longint'(d[15:0]);
            default: v = longint'(d);
        endcase
        t = longint'(thr);
        if (sgn) begin
            if (sz == 2'b00 && v >= P8 / 2)       v = v - P8;
            else if (sz == 2'b01 && v >= P16 / 2) v = v - P16;
            else if (sz[1] && v >= P31)           v = v - P32;
            if (t >= P31) t = t - P32;
        end
        return v > t;
    endfunction

    task automatic run_frame(input int len, input int cnt, input bit sgn, input bit oen,
                             input logic [31:0] thr, input int rdy_mode, input int val_mode);
        int  acc, rx, hits, ev_idx;
        bit  m_ov, m_bit, ev_next, exp_rdy, exp_done, xfer, finished;
        hits = 0;
        ev_idx = -1;
        for (int i = 0; i < len; i++) begin
            exp_hit[i] = model_hit(smp[i], ssz[i], sgn, thr);
            if (exp_hit[i] && hits < 65535) begin
                hits++;
                if (cnt != 0 && hits == cnt && ev_idx < 0) ev_idx = i;
            end
        end
        @(negedge clk);
        cfg_use_signed = sgn;
        cfg_out_enable = oen;
        cfg_threshold  = thr;
        cfg_len        = 16'(len);
        cfg_count      = 16'(cnt);
        cmd_start      = 1'b1;
        in_if.valid    = 1'b1;
        in_if.data     = $urandom;
        in_if.datasize = 2'b10;
        out_if.ready   = 1'b0;
        @(posedge clk);
        acc = 0; rx = 0; m_ov = 0; m_bit = 0; ev_next = 0; finished = 0;
        last_ev_seen = 0;
        for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
            @(negedge clk);
            cmd_start      = 1'b0;
            in_if.valid    = (val_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_if.data     = (acc < len) ? smp[acc] : $urandom;
            in_if.datasize = (acc < len) ? ssz[acc] : 2'b10;
            case (rdy_mode)
                0:       out_if.ready = 1'b1;
                1:       out_if.ready = 1'($urandom_range(0, 1));
                default: out_if.ready = !(cyc >= 1 && cyc <= 3);
            endcase
            #1;
            if (cyc == 0) begin
                n_checks++;
                if (count !== 16'd0) $display("FAIL start_clear_count got=%0d exp=0", count);
                else n_pass++;
            end
            n_checks++;
            if (out_if.valid !== m_ov) $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_if.valid, m_ov);
            else n_pass++;
            if (m_ov) begin
                n_checks++;
                if (out_if.data !== {31'b0, m_bit}) $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, out_if.data, {31'b0, m_bit});
                else n_pass++;
            end
            n_checks++;
            if (act_event !== ev_next) $display("FAIL act_event cyc=%0d got=%b exp=%b", cyc, act_event, ev_next);
            else n_pass++;
            if (act_event === 1'b1) last_ev_seen++;
            exp_rdy = (acc < len) && (!oen || !m_ov || out_if.ready);
            n_checks++;
            if (in_if.ready !== exp_rdy) $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_if.ready, exp_rdy);
            else n_pass++;
            exp_done = (acc == len) && !m_ov;
            n_checks++;
            if (done !== exp_done) $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, exp_done);
            else n_pass++;
            n_checks++;
            if (busy !== 1'b1) $display("FAIL busy_in_frame cyc=%0d got=%b exp=1", cyc, busy);
            else n_pass++;
            if (exp_done) finished = 1;
            xfer = in_if.valid && exp_rdy;
            if (m_ov && out_if.ready) begin
                if (rx < 16) rx_bits[rx] = out_if.data[0];
                rx++;
                m_ov = 0;
            end
            ev_next = xfer && (acc == ev_idx);
            if (xfer) begin
                if (oen) begin
                    m_ov  = 1;
                    m_bit = exp_hit[acc];
                end
                acc++;
            end
        end
        if (!finished) begin
            n_checks++;
            $display("FAIL frame_timeout got=no_done exp=done len=%0d", len);
        end
        rx_total = rx;
        @(negedge clk);
        in_if.valid = 1'b0;
        #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL post_done got=done%b busy%b exp=done0 busy0", done, busy);
        else n_pass++;
        n_checks++;
        if (count !== 16'(hits)) $display("FAIL hit_count got=%0d exp=%0d", count, hits);
        else n_pass++;
        n_checks++;
        if (last_ev_seen !== ((ev_idx >= 0) ? 1 : 0)) $display("FAIL event_count got=%0d exp=%0d", last_ev_seen, (ev_idx >= 0) ? 1 : 0);
        else n_pass++;
        n_checks++;
        if (rx !== (oen ? len : 0)) $display("FAIL outputs_delivered got=%0d exp=%0d", rx, oen ? len : 0);
        else n_pass++;
        n_checks++;
        if (out_if.datasize !== cfg_datasize) $display("FAIL out_datasize got=%b exp=%b", out_if.datasize, cfg_datasize);
        else n_pass++;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cfg_datasize = 2'b10;
        in_if.valid = 1'b0;
        in_if.data = '0;
        in_if.datasize = 2'b10;
        out_if.ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (out_if.valid !== 1'b0 || out_if.data !== 32'd0) $display("FAIL reset_out got=v%b d%h exp=v0 d0", out_if.valid, out_if.data);
        else n_pass++;
        n_checks++;
        if (out_if.datasize !== 2'b10) $display("FAIL reset_datasize got=%b exp=10", out_if.datasize);
        else n_pass++;
        n_checks++;
        if ({in_if.ready, act_event, done, busy} !== 4'b0 || count !== 16'd0)
            $display("FAIL reset_flags got=rdy%b ev%b dn%b bsy%b cnt%0d exp=0", in_if.ready, act_event, done, busy, count);
        else n_pass++;
        resetn = 1'b1;
    endtask

    task automatic test_unsigned_basic();
        logic [3:0] got;
        smp[0] = 32'd50; smp[1] = 32'd100; smp[2] = 32'd101; smp[3] = 32'd300;
        for (int i = 0; i < 4; i++) ssz[i] = 2'b10;
        run_frame(4, 0, 1'b0, 1'b1, 32'd100, 0, 0);
        for (int i = 0; i < 4; i++) got[i] = rx_bits[i];
        n_checks++;
        if (got !== 4'b1100) $display("FAIL unsigned_bits got=%b exp=1100", got);
        else n_pass++;
        n_checks++;
        if (count !== 16'd2) $display("FAIL unsigned_count got=%0d exp=2", count);
        else n_pass++;
    endtask

    task automatic test_signed_8b();
        logic [2:0] got;
        smp[0] = 32'hFF; smp[1] = 32'h01; smp[2] = 32'h80;
        for (int i = 0; i < 3; i++) ssz[i] = 2'b00;
        run_frame(3, 0, 1'b1, 1'b1, 32'd0, 0, 0);
        for (int i = 0; i < 3; i++) got[i] = rx_bits[i];
        n_checks++;
        if (got !== 3'b010) $display("FAIL signed8_bits got=%b exp=010", got);
        else n_pass++;
        run_frame(3, 0, 1'b0, 1'b1, 32'd0, 0, 0);
        for (int i = 0; i < 3; i++) got[i] = rx_bits[i];
        n_checks++;
        if (got !== 3'b111) $display("FAIL unsigned8_bits got=%b exp=111", got);
        else n_pass++;
    endtask

    task automatic test_event();
        smp[0] = 32'd5; smp[1] = 32'd200; smp[2] = 32'd7; smp[3] = 32'd300; smp[4] = 32'd9;
        for (int i = 0; i < 5; i++) ssz[i] = 2'b10;
        run_frame(5, 2, 1'b0, 1'b1, 32'd100, 0, 0);
        n_checks++;
        if (last_ev_seen !== 1) $display("FAIL event_once got=%0d exp=1", last_ev_seen);
        else n_pass++;
        run_frame(5, 0, 1'b0, 1'b1, 32'd100, 0, 0);
        n_checks++;
        if (last_ev_seen !== 0) $display("FAIL event_cnt0 got=%0d exp=0", last_ev_seen);
        else n_pass++;
    endtask

    task automatic test_back_to_back_stall();
        for (int i = 0; i < 4; i++) begin
            smp[i] = $urandom_range(0, 200);
            ssz[i] = 2'b10;
        end
        run_frame(4, 1, 1'b0, 1'b1, 32'd100, 2, 0);
        n_checks++;
        if (rx_total !== 4) $display("FAIL stall_delivered got=%0d exp=4", rx_total);
        else n_pass++;
    endtask

    task automatic test_restart();
        @(negedge clk);
        cfg_out_enable = 1'b1;
        cfg_use_signed = 1'b0;
        cfg_threshold  = 32'd0;
        cfg_len        = 16'd4;
        cfg_count      = 16'd0;
        cmd_start      = 1'b1;
        @(negedge clk);
        cmd_start      = 1'b0;
        in_if.valid    = 1'b1;
        in_if.data     = 32'd7;
        in_if.datasize = 2'b10;
        out_if.ready   = 1'b1;
        repeat (2) @(negedge clk);
        in_if.valid  = 1'b0;
        out_if.ready = 1'b0;
        #1;
        n_checks++;
        if (out_if.valid !== 1'b1 || count !== 16'd2) $display("FAIL restart_pre got=v%b cnt%0d exp=v1 cnt2", out_if.valid, count);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            smp[i] = $urandom;
            ssz[i] = 2'($urandom_range(0, 3));
        end
        run_frame(4, 1, 1'b0, 1'b1, 32'h4000_0000, 0, 0);
    endtask

    task automatic test_len_zero();
        run_frame(0, 0, 1'b0, 1'b1, 32'd0, 0, 0);
        n_checks++;
        if (count !== 16'd0) $display("FAIL len0_count got=%0d exp=0", count);
        else n_pass++;
    endtask

    task automatic test_no_output();
        for (int i = 0; i < 3; i++) begin
            smp[i] = 32'd90 + 32'(i) * 32'd10;
            ssz[i] = 2'b10;
        end
        run_frame(3, 0, 1'b0, 1'b0, 32'd95, 1, 0);
        n_checks++;
        if (count !== 16'd2) $display("FAIL noout_count got=%0d exp=2", count);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [31:0] thr;
        int len, cnt;
        for (int f = 0; f < 20; f++) begin
            thr = $urandom;
            if ($urandom_range(0, 1) == 1) thr = $urandom_range(0, 300);
            len = $urandom_range(1, 16);
            cnt = $urandom_range(0, len);
            cfg_datasize = 2'($urandom_range(0, 3));
            for (int i = 0; i < len; i++) begin
                ssz[i] = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0:       smp[i] = thr;
                    1:       smp[i] = thr + 32'd1;
                    2:       smp[i] = thr - 32'd1;
                    default: smp[i] = $urandom;
                endcase
            end
            run_frame(len, cnt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), thr, 1, 1);
        end
    endtask

    task automatic test_reset_midframe();
        @(negedge clk);
        cfg_out_enable = 1'b1;
        cfg_threshold  = 32'd0;
        cfg_len        = 16'd8;
        cmd_start      = 1'b1;
        @(negedge clk);
        cmd_start      = 1'b0;
        in_if.valid    = 1'b1;
        in_if.data     = 32'd5;
        in_if.datasize = 2'b10;
        out_if.ready   = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, out_if.valid} !== 3'b000 || count !== 16'd0)
            $display("FAIL reset_mid got=bsy%b dn%b v%b cnt%0d exp=0", busy, done, out_if.valid, count);
        else n_pass++;
        in_if.valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({busy, done} !== 2'b00) $display("FAIL after_reset got=bsy%b dn%b exp=0", busy, done);
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_unsigned_basic();
        test_signed_8b();
        test_event();
        test_back_to_back_stall();
        test_restart();
        test_len_zero();
        test_no_output();
        test_random();
        test_reset_midframe();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
